// File: rtl/float_unit_arbiter.sv
// Round-robin arbiter sharing one float adder/multiplier between NUM_REQ requesters.
// Define FLOAT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state       | meaning
// ST_IDLE     | no owner; pick next requester, latch its operands, pulse its AB_ACK
// ST_ISSUE    | present operands to the unit until it accepts them
// ST_WAIT_Z   | wait for the unit result, capture it and pulse the unit Z_ACK
// ST_DELIVER  | hold result to the owner until it acknowledges
module float_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTN,
    input  logic [32*NUM_REQ-1:0]   i_REQ_A,
    input  logic [32*NUM_REQ-1:0]   i_REQ_B,
    input  logic [NUM_REQ-1:0]      i_REQ_AB_STB,
    output logic [NUM_REQ-1:0]      o_REQ_AB_ACK,
    output logic [31:0]             o_REQ_Z,
    output logic [NUM_REQ-1:0]      o_REQ_Z_STB,
    input  logic [NUM_REQ-1:0]      i_REQ_Z_ACK,
    output logic [31:0]             o_UNIT_A,
    output logic [31:0]             o_UNIT_B,
    output logic                    o_UNIT_AB_STB,
    input  logic                    i_UNIT_AB_ACK,
    input  logic [31:0]             i_UNIT_Z,
    input  logic                    i_UNIT_Z_STB,
    output logic                    o_UNIT_Z_ACK,
    output logic [NUM_REQ-1:0]      o_GRANT,
    output logic                    o_BUSY
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_Z,
        ST_DELIVER
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] scan_base;
    logic             sel_found;

`ifdef FLOAT_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    assign scan_base = rr_ptr;
`endif

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // First pending requester found scanning upward from scan_base with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && i_REQ_AB_STB[wrap_add(scan_base, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(scan_base, i);
            end
        end
    end

    assign o_BUSY = (state != ST_IDLE);

    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            state         <= ST_IDLE;
            grant_idx     <= '0;
            o_REQ_AB_ACK  <= '0;
            o_REQ_Z       <= '0;
            o_REQ_Z_STB   <= '0;
            o_UNIT_A      <= '0;
            o_UNIT_B      <= '0;
            o_UNIT_AB_STB <= 1'b0;
            o_UNIT_Z_ACK  <= 1'b0;
            o_GRANT       <= '0;
`ifndef FLOAT_ARB_FIXED_PRIO_EN
            rr_ptr        <= '0;
`endif
        end else begin
            o_REQ_AB_ACK <= '0;
            o_UNIT_Z_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_idx     <= sel_idx;
                        o_UNIT_A      <= i_REQ_A[32*sel_idx +: 32];
                        o_UNIT_B      <= i_REQ_B[32*sel_idx +: 32];
                        o_GRANT       <= ONE_HOT0 << sel_idx;
                        o_REQ_AB_ACK  <= ONE_HOT0 << sel_idx;
                        o_UNIT_AB_STB <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_UNIT_AB_ACK) begin
                        o_UNIT_AB_STB <= 1'b0;
                        state         <= ST_WAIT_Z;
                    end
                end
                ST_WAIT_Z: begin
                    if (i_UNIT_Z_STB) begin
                        o_REQ_Z      <= i_UNIT_Z;
                        o_REQ_Z_STB  <= ONE_HOT0 << grant_idx;
                        o_UNIT_Z_ACK <= 1'b1;
                        state        <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (i_REQ_Z_ACK[grant_idx]) begin
                        o_REQ_Z_STB <= '0;
                        o_GRANT     <= '0;
`ifndef FLOAT_ARB_FIXED_PRIO_EN
                        rr_ptr      <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Scoreboard bench for float_unit_arbiter: requester models, a mock float multiplier
// and a monitor popping expected ACK/operand/result events.
module tb_float_unit_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ab_stb, req_ab_ack, req_z_stb, req_z_ack, grant;
    logic [31:0]  req_z, unit_a, unit_b, unit_z;
    logic         unit_ab_stb, unit_ab_ack, unit_z_stb, unit_z_ack, busy;

    always #5 clk = ~clk;

    float_unit_arbiter #(.NUM_REQ(4), .PTR_W(2)) dut (
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_REQ_A(req_a), .i_REQ_B(req_b), .i_REQ_AB_STB(req_ab_stb), .o_REQ_AB_ACK(req_ab_ack),
        .o_REQ_Z(req_z), .o_REQ_Z_STB(req_z_stb), .i_REQ_Z_ACK(req_z_ack),
        .o_UNIT_A(unit_a), .o_UNIT_B(unit_b), .o_UNIT_AB_STB(unit_ab_stb), .i_UNIT_AB_ACK(unit_ab_ack),
        .i_UNIT_Z(unit_z), .i_UNIT_Z_STB(unit_z_stb), .o_UNIT_Z_ACK(unit_z_ack),
        .o_GRANT(grant), .o_BUSY(busy)
    );

    // Per-requester operands and hand-computed IEEE-754 products.
    logic [31:0] op_a [4] = '{32'h40000000, 32'h3fc00000, 32'h3f800000, 32'hbf800000};
    logic [31:0] op_b [4] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    logic [31:0] op_z [4] = '{32'h40800000, 32'h40400000, 32'h40000000, 32'hc0000000};

    int checks = 0;
    int failures = 0;
    int pending [4];
    int ack_delay, z_delay, zack_delay;
    logic stray0;
    int zack_cnt = 0;
    int um_state = 0;

    logic [3:0]  exp_ack [$];
    logic [63:0] exp_op  [$];
    logic [35:0] exp_z   [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_op(input int k);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        exp_ack.push_back(oh);
        exp_op.push_back({op_a[k], op_b[k]});
        exp_z.push_back({oh, op_z[k]});
    endtask

    function automatic logic [31:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h3fc00000, 32'h40000000}: return 32'h40400000;
            {32'h3f800000, 32'h40000000}: return 32'h40000000;
            {32'hbf800000, 32'h40000000}: return 32'hc0000000;
            default:                      return 32'hdeadbeef;
        endcase
    endfunction

    // Requester models: hold STB while operations remain, acknowledge results after zack_delay.
    initial begin
        int zc [4];
        logic [3:0] zk;
        for (int k = 0; k < 4; k++) zc[k] = 0;
        req_ab_stb = '0;
        req_z_ack  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rst_n && req_ab_ack[k] && pending[k] > 0) pending[k]--;
                if (rst_n && req_z_stb[k]) zc[k]++;
                else zc[k] = 0;
                zk[k] = rst_n && req_z_stb[k] && (zc[k] > zack_delay);
                req_ab_stb[k] = (pending[k] > 0);
            end
            req_z_ack = zk | {3'b000, stray0};
        end
    end

    // Mock float unit with programmable accept and result latency.
    initial begin
        int um_cnt;
        logic [63:0] first_op;
        um_cnt = 0;
        first_op = '0;
        unit_ab_ack = 1'b0;
        unit_z_stb  = 1'b0;
        unit_z      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                um_state = 0; um_cnt = 0; unit_ab_ack = 1'b0; unit_z_stb = 1'b0;
            end else begin
                case (um_state)
                    0: begin
                        if (unit_ab_stb) begin
                            if (um_cnt == 0) first_op = {unit_a, unit_b};
                            else check("issue_operands_held", {unit_a, unit_b}, first_op);
                            if (um_cnt >= ack_delay) begin
                                unit_ab_ack = 1'b1;
                                if (exp_op.size() == 0) fail_now("unexpected_issue");
                                else check("unit_operands", {unit_a, unit_b}, exp_op.pop_front());
                                um_state = 1;
                            end else um_cnt++;
                        end else if (um_cnt != 0) begin
                            fail_now("issue_stb_dropped_early");
                            um_cnt = 0;
                        end
                    end
                    1: begin
                        unit_ab_ack = 1'b0; um_cnt = 0; um_state = 2;
                    end
                    2: begin
                        if (um_cnt >= z_delay) begin
                            unit_z = mul_lut(first_op[63:32], first_op[31:0]);
                            unit_z_stb = 1'b1;
                            um_state = 3;
                        end else um_cnt++;
                    end
                    default: begin
                        if (unit_z_ack) begin
                            unit_z_stb = 1'b0; um_cnt = 0; um_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an ACK or a new result.
    initial begin
        logic [3:0] prev_zstb;
        int zlen;
        prev_zstb = '0;
        zlen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_zstb = '0; zlen = 0;
            end else begin
                if (unit_z_ack) zack_cnt++;
                if (req_ab_ack != 0) begin
                    check("grant_matches_ack", grant, req_ab_ack);
                    if (exp_ack.size() == 0) fail_now("unexpected_ab_ack");
                    else check("ab_ack", req_ab_ack, exp_ack.pop_front());
                end
                if (req_z_stb != 0 && prev_zstb == 0) begin
                    check("grant_matches_zstb", grant, req_z_stb);
                    if (exp_z.size() == 0) fail_now("unexpected_z_stb");
                    else check("result", {req_z_stb, req_z}, exp_z.pop_front());
                end
                if (req_z_stb != 0) zlen++;
                else if (prev_zstb != 0) begin
                    check("z_stb_hold_cycles", zlen, zack_delay + 1);
                    zlen = 0;
                end
                prev_zstb = req_z_stb;
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_ack.size() != 0 || exp_op.size() != 0 || exp_z.size() != 0 || busy ||
                pending[0] + pending[1] + pending[2] + pending[3] != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            fail_now({name, "_timeout"});
            exp_ack.delete(); exp_op.delete(); exp_z.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {req_ab_ack, req_z, req_z_stb, unit_a, unit_b, unit_ab_stb, unit_z_ack, grant, busy}, '0);
    endtask

    initial begin
        int n;
        int zack_before;
        rst_n = 1'b0;
        stray0 = 1'b0;
        ack_delay = 0; z_delay = 1; zack_delay = 0;
        for (int k = 0; k < 4; k++) pending[k] = 0;
        for (int k = 0; k < 4; k++) begin
            req_a[32*k +: 32] = op_a[k];
            req_b[32*k +: 32] = op_b[k];
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;

        // Single request from requester 2, result held two extra cycles.
        zack_delay = 2;
        expect_op(2);
        pending[2] = 1;
        wait_done("single", 200);
        check("single_grant_cleared", grant, 4'b0000);
        check("single_busy_cleared", busy, 1'b0);

        // Wrap-around: pointer sits at 3 after serving requester 2.
        zack_delay = 0;
`ifdef FLOAT_ARB_FIXED_PRIO_EN
        expect_op(1); expect_op(3);
`else
        expect_op(3); expect_op(1);
`endif
        pending[1] = 1; pending[3] = 1;
        wait_done("wrap", 300);

        // Unit stall on both handshakes, stray result ACK from requester 0.
        ack_delay = 5; z_delay = 10; zack_delay = 3;
        stray0 = 1'b1;
        zack_before = zack_cnt;
        expect_op(1);
        pending[1] = 1;
        repeat (4) @(negedge clk);
        check("stall_busy", busy, 1'b1);
        check("stall_unit_stb", unit_ab_stb, 1'b1);
        check("stall_grant", grant, 4'b0010);
        wait_done("stall", 300);
        stray0 = 1'b0;
        check("stall_unit_zack_cycles", zack_cnt - zack_before, 1);
        ack_delay = 0; z_delay = 1; zack_delay = 0;

        // Reset while waiting for the unit result; pending requests re-granted from pointer 0.
        z_delay = 20;
        exp_ack.push_back(4'b0100);
        exp_op.push_back({op_a[2], op_b[2]});
        pending[2] = 1;
        n = 0;
        while (um_state != 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("reset_test_wait_z_timeout");
        repeat (2) @(negedge clk);
        pending[0] = 1; pending[3] = 1;
        repeat (2) @(negedge clk);
        check("wait_z_ignores_requests", grant, 4'b0100);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midop_reset_outputs");
        expect_op(0); expect_op(3);
        z_delay = 1;
        rst_n = 1'b1;
        wait_done("after_reset", 300);

        // All four strobing together; requester 0 wants two operations.
`ifdef FLOAT_ARB_FIXED_PRIO_EN
        expect_op(0); expect_op(0); expect_op(1); expect_op(2); expect_op(3);
`else
        expect_op(0); expect_op(1); expect_op(2); expect_op(3); expect_op(0);
`endif
        pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
        wait_done("all_four", 600);
        check("final_grant_cleared", grant, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
